// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Shared definitions for the 4:1 round-robin arbitrated multiplexer.
//   arb_state_t : arbiter FSM states (IDLE = no owner, GRANT = one owner)
//   NUM_REQ     : number of requesters sharing the channel
//   IDX_W       : width of a requester index
// ---------------------------------------------------------------------------
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

endpackage

// File: rtl/mux_4_1_arbiter_mux.sv
// ---------------------------------------------------------------------------
// MUX_4_1
// Gated 4:1 single-bit multiplexer forming the arbiter datapath.
// Ports:
//   enable     : when low the output is forced to 0
//   select     : index of the data input routed to the output
//   data_0..3  : candidate data bits
//   data_out   : selected bit, or 0 when disabled
// ---------------------------------------------------------------------------
module MUX_4_1
    import mux_arb_pkg::*;
(
    input  logic             enable,
    input  logic [IDX_W-1:0] select,
    input  logic             data_0,
    input  logic             data_1,
    input  logic             data_2,
    input  logic             data_3,
    output logic             data_out
);

    // Pure combinational select; the disabled case yields 0 so an idle
    // channel never leaks a requester's data.
    always_comb begin
        data_out = 1'b0;
        if (enable) begin
            case (select)
                2'd0:    data_out = data_0;
                2'd1:    data_out = data_1;
                2'd2:    data_out = data_2;
                default: data_out = data_3;
            endcase
        end
    end

endmodule

// File: rtl/mux_4_1_arbiter.sv
// ---------------------------------------------------------------------------
// mux_4_1_arbiter
// Round-robin arbiter granting one of four requesters a shared single-bit
// channel, with a bounded hold time per grant.
// Parameters:
//   MAX_HOLD     : max consecutive cycles one owner keeps the grant (1..255)
// Ports:
//   Clock_In     : clock, rising edge
//   Reset_n_In   : synchronous active-low reset
//   Request_In   : request vector, bit i = requester i wants the channel
//   Data_0..3_In : per-requester data bits
//   Grant_Out    : registered one-hot grant, zero when idle
//   Select_Out   : registered index of the current owner
//   Enable_Out   : registered, high while a grant is active
//   MUX_Data_Out : data of the current owner, 0 when idle
//   Busy_Out     : registered copy of Enable_Out
// ---------------------------------------------------------------------------
module mux_4_1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               Clock_In,
    input  logic               Reset_n_In,
    input  logic [NUM_REQ-1:0] Request_In,
    input  logic               Data_0_In,
    input  logic               Data_1_In,
    input  logic               Data_2_In,
    input  logic               Data_3_In,
    output logic [NUM_REQ-1:0] Grant_Out,
    output logic [IDX_W-1:0]   Select_Out,
    output logic               Enable_Out,
    output logic               MUX_Data_Out,
    output logic               Busy_Out
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [7:0]       hold_cnt;
    logic [IDX_W-1:0] last_grant;

    logic [IDX_W-1:0] search_ptr;
    logic [IDX_W:0]   pick;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             release_evt;

    // Round-robin search starting just after ptr; the pointer itself is
    // visited last so a lone still-requesting owner can be regranted.
    // Returns {found, index}. Iterating from the farthest candidate down
    // lets the nearest requesting index overwrite the result.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    // While granting, the search pointer is the current owner; an owner
    // that dropped its request is naturally skipped because its bit is low.
    always_comb begin
        search_ptr  = (state == GRANT) ? Select_Out : last_grant;
        pick        = rr_pick(Request_In, search_ptr);
        pick_found  = pick[IDX_W];
        pick_idx    = pick[IDX_W-1:0];
        release_evt = (state == GRANT) &&
                      (!Request_In[Select_Out] || (hold_cnt == HOLD_LAST));
    end

    // Arbiter FSM with all outputs registered. A release arbitrates in the
    // same cycle so the next owner follows without an idle bubble.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            state      <= IDLE;
            Grant_Out  <= '0;
            Select_Out <= '0;
            Enable_Out <= 1'b0;
            Busy_Out   <= 1'b0;
            hold_cnt   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state      <= GRANT;
                        Grant_Out  <= NUM_REQ'(1) << pick_idx;
                        Select_Out <= pick_idx;
                        Enable_Out <= 1'b1;
                        Busy_Out   <= 1'b1;
                        hold_cnt   <= '0;
                        last_grant <= pick_idx;
                    end
                end
                GRANT: begin
                    if (!release_evt) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end else if (pick_found) begin
                        Grant_Out  <= NUM_REQ'(1) << pick_idx;
                        Select_Out <= pick_idx;
                        Enable_Out <= 1'b1;
                        Busy_Out   <= 1'b1;
                        hold_cnt   <= '0;
                        last_grant <= pick_idx;
                    end else begin
                        state      <= IDLE;
                        Grant_Out  <= '0;
                        Select_Out <= '0;
                        Enable_Out <= 1'b0;
                        Busy_Out   <= 1'b0;
                        hold_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shared channel datapath driven by the registered grant.
    MUX_4_1 u_mux (
        .enable   (Enable_Out),
        .select   (Select_Out),
        .data_0   (Data_0_In),
        .data_1   (Data_1_In),
        .data_2   (Data_2_In),
        .data_3   (Data_3_In),
        .data_out (MUX_Data_Out)
    );

endmodule
